// File: rtl/regbank8_sb.sv
// 8 x WIDTH register bank with a pending-write scoreboard.
// The stall output keeps a consumer from reading a register whose producer has not retired yet.
module regbank8_sb #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             pend_set,
  input  logic [2:0]       pend_addr,
  input  logic [2:0]       rs,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [7:0]       busy,
  output logic             stall
);

  logic [WIDTH-1:0] regs [8];
  logic [7:0]       busy_nxt;
  logic             wr_ok;
  logic             set_ok;

  assign wr_ok  = we && !(ZERO_REG0 && (wa == 3'd0));
  assign set_ok = pend_set && !(ZERO_REG0 && (pend_addr == 3'd0));

  // Set is applied after clear so a new producer issued on the retiring edge wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[wa] = 1'b0;
    if (set_ok)
      busy_nxt[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++)
        regs[i] <= '0;
      busy <= 8'h00;
    end else begin
      if (wr_ok)
        regs[wa] <= wd;
      busy <= busy_nxt;
    end
  end

  assign stall = busy[rs] & ~(we & (wa == rs) & ~(pend_set & (pend_addr == rs)));

  assign q0 = ZERO_REG0 ? '0 : regs[0];
  assign q1 = regs[1];
  assign q2 = regs[2];
  assign q3 = regs[3];
  assign q4 = regs[4];
  assign q5 = regs[5];
  assign q6 = regs[6];
  assign q7 = regs[7];

endmodule

// File: tb/tb_regbank8_sb.sv
// Directed and randomized checks of regbank8_sb against a behavioural register/scoreboard model.
module tb_regbank8_sb;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             we;
  logic [2:0]       wa;
  logic [WIDTH-1:0] wd;
  logic             pend_set;
  logic [2:0]       pend_addr;
  logic [2:0]       rs;
  logic [WIDTH-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]       busy;
  logic             stall;
  logic [WIDTH-1:0] qv [8];

  int n_checks = 0;
  int n_fail   = 0;

  // model: register contents and the set of pending registers
  logic [WIDTH-1:0] mq [8];
  bit               mpend [8];

  regbank8_sb #(.WIDTH(WIDTH), .ZERO_REG0(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .pend_set(pend_set), .pend_addr(pend_addr), .rs(rs),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .busy(busy), .stall(stall)
  );

  assign qv[0] = q0; assign qv[1] = q1; assign qv[2] = q2; assign qv[3] = q3;
  assign qv[4] = q4; assign qv[5] = q5; assign qv[6] = q6; assign qv[7] = q7;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mq[i] = '0;
      mpend[i] = 1'b0;
    end
  endfunction

  // One clock edge: register 0 is hardwired zero and can never be pending.
  function automatic void model_clock();
    if (we && wa != 3'd0) begin
      mq[wa] = wd;
      mpend[wa] = 1'b0;
    end
    if (pend_set && pend_addr != 3'd0)
      mpend[pend_addr] = 1'b1;
  endfunction

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      if (mpend[i]) b = b | (8'h01 << i);
    return b;
  endfunction

  // Pending source stalls unless its producer retires now and no new producer replaces it.
  function automatic logic model_stall();
    logic retiring;
    logic reissued;
    retiring = we && (wa == rs);
    reissued = pend_set && (pend_addr == rs);
    return mpend[rs] && !(retiring && !reissued);
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_q%0d", tag, i), qv[i], mq[i]);
    check({tag, "_busy"}, {24'h0, busy}, {24'h0, model_busy()});
  endtask

  task automatic drive(input logic w, input logic [2:0] a, input logic [WIDTH-1:0] d,
                       input logic ps, input logic [2:0] pa, input logic [2:0] r);
    we = w; wa = a; wd = d; pend_set = ps; pend_addr = pa; rs = r;
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, {31'h0, stall}, {31'h0, model_stall()});
    @(posedge clk);
    model_clock();
    #1;
    check_regs(tag);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd0);
    model_reset();
    #40 rst = 1'b1;
    #1;
    check_regs("reset");
    for (int i = 0; i < 8; i++) begin
      rs = 3'(i);
      #1;
      check($sformatf("reset_stall_rs%0d", i), {31'h0, stall}, 32'h0);
    end
    @(posedge clk);
    #1;

    // single write, visible next cycle through the mux position rs=3
    drive(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 3'd3);
    tick("wr3");
    check("wr3_q3_const", q3, 32'hDEADBEEF);
    check("wr3_mux_y", qv[rs], 32'hDEADBEEF);

    // set pending, then retire it
    drive(1'b0, 3'd0, '0, 1'b1, 3'd5, 3'd5);
    tick("set5");
    check("set5_busy_const", {24'h0, busy}, 32'h20);
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd5);
    #1;
    check("set5_stall_held", {31'h0, stall}, 32'h1);
    drive(1'b1, 3'd5, 32'h12345678, 1'b0, 3'd0, 3'd5);
    #1;
    check("wr5_stall_release", {31'h0, stall}, 32'h0);
    tick("wr5");
    check("wr5_busy_const", {24'h0, busy}, 32'h00);

    // set and write the same register on the same edge
    drive(1'b1, 3'd2, 32'hA5A5A5A5, 1'b1, 3'd2, 3'd2);
    tick("setwr2");
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd2);
    #1;
    check("setwr2_stall", {31'h0, stall}, 32'h1);
    check("setwr2_q2_const", q2, 32'hA5A5A5A5);

    // set on one register, write to another; repeated set on a pending one
    drive(1'b1, 3'd6, 32'h0BADF00D, 1'b1, 3'd1, 3'd1);
    tick("indep");
    drive(1'b0, 3'd0, '0, 1'b1, 3'd1, 3'd1);
    tick("reset1");

    // register 0 ignores writes and pending marks
    drive(1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 3'd0, 3'd0);
    tick("zero0");
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd0);
    #1;
    check("zero0_stall", {31'h0, stall}, 32'h0);
    check("zero0_q0_const", q0, 32'h0);

    // clear outstanding marks so the next block starts from busy=F0 exactly
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'(i * 32'h1111), 1'b0, 3'd0, 3'(i));
      tick("drain");
    end
    drive(1'b1, 3'd7, 32'h00000007, 1'b0, 3'd0, 3'd7);
    tick("wr7");
    for (int i = 4; i < 8; i++) begin
      drive(1'b0, 3'd0, '0, 1'b1, 3'(i), 3'(i));
      tick("setF0");
    end
    check("setF0_busy_const", {24'h0, busy}, 32'hF0);
    drive(1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd0);

    // asynchronous reset between edges
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_q7", q7, 32'h0);
    check("async_busy", {24'h0, busy}, 32'h0);
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_regs("post_async");

    // randomized traffic, biased so writes often hit pending registers
    for (int n = 0; n < 400; n++) begin
      logic [2:0] pick;
      pick = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 99) < 45), ($urandom_range(0, 1) != 0) ? pick : 3'($urandom_range(0, 7)),
            $urandom(), 1'($urandom_range(0, 99) < 40), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) != 0) ? pick : 3'($urandom_range(0, 7)));
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
